core_mem_ctrl: RTL



---
 rtl/core_mem_ctrl_pkg.sv | 29 ++
 rtl/core_mem_ctrl_arb.sv | 31 +++
 rtl/core_mem_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/core_mem_ctrl_pkg.sv
// rtl/core_mem_ctrl_pkg.sv - shared widths, length codes and FSM encoding for core_mem_ctrl
package core_mem_ctrl_pkg;

  localparam int K_C_DATA_L = 32;
  localparam int K_M_ADDR_L = 32;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [2:0] {
    MC_IDLE    = 3'd0,
    MC_RD      = 3'd1,
    MC_RD_LAST = 3'd2,
    MC_WR      = 3'd3,
    MC_ACK     = 3'd4
  } mc_state_e;

  // Replace byte lane `lane` of a little-endian word.
  function automatic logic [K_C_DATA_L-1:0] lane_insert(input logic [K_C_DATA_L-1:0] word,
                                                        input logic [1:0]            lane,
                                                        input logic [7:0]            b);
    logic [K_C_DATA_L-1:0] r;
    r = word;
    r[8*lane +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/core_mem_ctrl_arb.sv
// rtl/core_mem_ctrl_arb.sv - fixed-priority grant: write, then highest-numbered read port
module core_mem_arb #(
  parameter int R_PORT = 2,
  parameter int PW     = 1
) (
  input  logic              we,
  input  logic [R_PORT-1:0] re,
  output logic              gnt_valid,
  output logic              gnt_write,
  output logic [PW-1:0]     gnt_port
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_write = 1'b0;
    gnt_port  = '0;
    if (we) begin
      gnt_valid = 1'b1;
      gnt_write = 1'b1;
    end else begin
      // ascending scan, last hit wins, so the higher port index takes priority
      for (int i = 0; i < R_PORT; i++) begin
        if (re[i]) begin
          gnt_valid = 1'b1;
          gnt_port  = PW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/core_mem_ctrl.sv
// rtl/core_mem_ctrl.sv - serialises core read/write ports onto a byte-wide synchronous RAM
module core_mem_ctrl
  import core_mem_ctrl_pkg::*;
#(
  parameter int R_PORT     = 2,
  parameter int W_PORT     = 1,
  parameter int MEM_ADDR_W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [R_PORT*32-1:0]     co_din,
  input  logic [W_PORT*32-1:0]     co_dout,
  input  logic [R_PORT*32-1:0]     co_raddr,
  input  logic [W_PORT*32-1:0]     co_waddr,
  input  logic [R_PORT-1:0]        co_re,
  input  logic [W_PORT-1:0]        co_we,
  input  logic [R_PORT*2-1:0]      co_rlen,
  input  logic [W_PORT*2-1:0]      co_wlen,
  output logic [R_PORT-1:0]        co_rack,
  output logic [W_PORT-1:0]        co_wack,
  output logic [MEM_ADDR_W-1:0]    mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_we,
  input  logic [7:0]               mem_rdata
);

  localparam int PW = (R_PORT > 1) ? $clog2(R_PORT) : 1;

  mc_state_e              state_q, state_d;
  logic [1:0]             k_q;
  logic [1:0]             len_q;
  logic [PW-1:0]          port_q;
  logic [K_M_ADDR_L-1:0]  addr_q;
  logic [K_C_DATA_L-1:0]  wdata_q;
  logic [K_C_DATA_L-1:0]  asm_q;
  logic [K_M_ADDR_L-1:0]  addr_sum;
  logic                   unused_addr_bits;

  logic                   gnt_valid;
  logic                   gnt_write;
  logic [PW-1:0]          gnt_port;

  core_mem_arb #(
    .R_PORT (R_PORT),
    .PW     (PW)
  ) u_arb (
    .we        (co_we[0]),
    .re        (co_re),
    .gnt_valid (gnt_valid),
    .gnt_write (gnt_write),
    .gnt_port  (gnt_port)
  );

  // Full-width sum, truncated at the RAM port so addresses wrap at 2^MEM_ADDR_W.
  assign addr_sum         = addr_q + K_M_ADDR_L'(k_q);
  assign unused_addr_bits = ^addr_sum;

  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (gnt_valid) state_d = gnt_write ? MC_WR : MC_RD;
      end
      MC_RD: begin
        mem_addr = addr_sum[MEM_ADDR_W-1:0];
        if (k_q == len_q) state_d = MC_RD_LAST;
      end
      MC_RD_LAST: begin
        state_d = MC_ACK;
      end
      MC_WR: begin
        mem_addr  = addr_sum[MEM_ADDR_W-1:0];
        mem_wdata = wdata_q[8*k_q +: 8];
        mem_we    = 1'b1;
        if (k_q == len_q) state_d = MC_ACK;
      end
      MC_ACK: begin
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MC_IDLE;
      k_q     <= 2'd0;
      len_q   <= LEN_B;
      port_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      co_din  <= '0;
      co_rack <= '0;
      co_wack <= '0;
    end else begin
      state_q <= state_d;
      co_rack <= '0;
      co_wack <= '0;
      case (state_q)
        MC_IDLE: begin
          if (gnt_valid) begin
            port_q <= gnt_port;
            k_q    <= 2'd0;
            asm_q  <= '0;
            if (gnt_write) begin
              addr_q  <= co_waddr[K_M_ADDR_L-1:0];
              len_q   <= co_wlen[1:0];
              wdata_q <= co_dout[K_C_DATA_L-1:0];
            end else begin
              addr_q <= co_raddr[gnt_port*32 +: 32];
              len_q  <= co_rlen[gnt_port*2 +: 2];
            end
          end
        end
        MC_RD: begin
          // RAM data lags its address by one cycle, so lane k-1 arrives while k is driven
          if (k_q != 2'd0) asm_q <= lane_insert(asm_q, k_q - 2'd1, mem_rdata);
          if (k_q != len_q) k_q <= k_q + 2'd1;
        end
        MC_RD_LAST: begin
          asm_q                   <= lane_insert(asm_q, len_q, mem_rdata);
          co_din[port_q*32 +: 32] <= lane_insert(asm_q, len_q, mem_rdata);
          co_rack[port_q]         <= 1'b1;
        end
        MC_WR: begin
          if (k_q != len_q) k_q <= k_q + 2'd1;
          else              co_wack[0] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
